// File: rtl/timer_pkg.sv
// timer_pkg: shared types and defaults for the timer blocks.
//   mode_e      : pin mode select (off, toggle, PWM, one-shot)
//   out_state_e : output-stage FSM states
//   DEF_CNT_W   : default counter / config width
package timer_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    TOGGLE  = 2'b01,
    PWM     = 2'b10,
    ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACTIVE   = 2'b01,
    INACTIVE = 2'b10
  } out_state_e;

endpackage

// File: rtl/out_hold_filter.sv
// out_hold_filter: enforces a minimum hold time on a pin level.
//   clk, rst      : clock, async active-high reset
//   level         : requested level
//   applied_level : level actually applied (combinational); follows level only
//                   once the current value has been held MIN_HOLD clk cycles.
// A change requested early is applied as soon as the hold expires; if level
// returns to the applied value first, no edge is ever produced.
module out_hold_filter #(
  parameter int MIN_HOLD = 2  // 1..15
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic applied_level
);

  localparam logic [3:0] HOLD_MAX = 4'(MIN_HOLD);

  logic [3:0] hold_cnt;
  logic       held;

  assign applied_level = (hold_cnt == HOLD_MAX) ? level : held;

  // hold_cnt is 1 in the first cycle a new value is held, so a change can
  // be taken again exactly MIN_HOLD cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      held     <= 1'b0;
    end else begin
      held <= applied_level;
      if (applied_level != held)
        hold_cnt <= 4'd1;
      else if (hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/output_block.sv
// output_block: timer output stage driving an external waveform pin.
//   clk, rst        : clock, async active-high reset
//   enable          : block enable, low forces idle
//   tick            : one-clk advance strobe from the timer
//   mode            : 00 off, 01 toggle, 10 PWM, 11 one-shot
//   period          : ticks per cycle (toggle: ticks per half-cycle)
//   high_time       : active ticks (PWM, one-shot)
//   polarity        : 1 = active-low pin
//   start           : one-shot trigger
//   pin_out         : registered pin drive, every level held >= MIN_HOLD clk
//   cycle_done      : one-clk pulse at end of period / end of one-shot pulse
//   busy            : generator running or one-shot active
// Build option: define SHADOW_CFG_EN to use period/high_time through shadow
// registers reloaded while idle and at each cycle end, so mid-cycle config
// writes take effect from the next cycle.
module output_block
  import timer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MIN_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  input  logic             polarity,
  input  logic             start,
  output logic             pin_out,
  output logic             cycle_done,
  output logic             busy
);

  out_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       mode_q;
  logic             done_nx;
  logic [CNT_W-1:0] per_e, hi_e;
  logic             level, applied_level;
  logic             halt, at_end, at_high, wrap_active;
  mode_e            mode_i;

  assign mode_i = mode_e'(mode);

`ifdef SHADOW_CFG_EN
  logic [CNT_W-1:0] per_sh, hi_sh;

  // While idle nothing is in flight, so the live value is what the next
  // cycle will start with; the shadow captures it at the same moment.
  assign per_e = (state == IDLE) ? period    : per_sh;
  assign hi_e  = (state == IDLE) ? high_time : hi_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_sh <= '0;
      hi_sh  <= '0;
    end else if (state == IDLE || done_nx) begin
      per_sh <= period;
      hi_sh  <= high_time;
    end
  end
`else
  assign per_e = period;
  assign hi_e  = high_time;
`endif

  // A mode change always costs one clk in IDLE before the new mode runs.
  assign halt    = !enable || (mode_i == OFF) ||
                   (mode_i != ONESHOT && per_e == '0) || (mode != mode_q);
  assign at_end  = cnt >= per_e - 1'b1;
  assign at_high = (hi_e == '0) || (cnt >= hi_e - 1'b1);
  // Next cycle's start level uses the value being loaded at this wrap.
  assign wrap_active = (high_time != '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    if (halt) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (mode_i)
        PWM: begin
          if (state == IDLE) begin
            state_nx = (hi_e != '0) ? ACTIVE : INACTIVE;
            cnt_nx   = '0;
          end else if (tick) begin
            if (at_end) begin
              cnt_nx   = '0;
              done_nx  = 1'b1;
              state_nx = wrap_active ? ACTIVE : INACTIVE;
            end else begin
              cnt_nx = cnt + 1'b1;
              if (state == ACTIVE && at_high) state_nx = INACTIVE;
            end
          end
        end
        TOGGLE: begin
          if (state == IDLE) begin
            state_nx = ACTIVE;
            cnt_nx   = '0;
          end else if (tick) begin
            if (at_end) begin
              cnt_nx   = '0;
              done_nx  = 1'b1;
              state_nx = (state == ACTIVE) ? INACTIVE : ACTIVE;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        ONESHOT: begin
          // start wins over a same-clk tick: the pulse starts at cnt 0.
          if (state == IDLE) begin
            if (start && hi_e != '0) begin
              state_nx = ACTIVE;
              cnt_nx   = '0;
            end
          end else if (tick) begin
            if (at_high) begin
              state_nx = IDLE;
              cnt_nx   = '0;
              done_nx  = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign level = (state == ACTIVE);

  out_hold_filter #(.MIN_HOLD(MIN_HOLD)) u_hold (
    .clk          (clk),
    .rst          (rst),
    .level        (level),
    .applied_level(applied_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= 2'b00;
      cycle_done <= 1'b0;
      busy       <= 1'b0;
      pin_out    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      mode_q     <= mode;
      cycle_done <= done_nx;
      busy       <= (state_nx != IDLE);
      pin_out    <= applied_level ^ polarity;
    end
  end

endmodule

// File: tb/tb_output_block.sv
module tb_output_block;

  localparam int MIN_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, tick = 1'b0, polarity = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] period = 8'd0, high_time = 8'd0;
  logic       pin_out, cycle_done, busy;

  int total = 0;
  int bad   = 0;

  output_block #(.CNT_W(8), .MIN_HOLD(MIN_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tick      (tick),
    .mode      (mode),
    .period    (period),
    .high_time (high_time),
    .polarity  (polarity),
    .start     (start),
    .pin_out   (pin_out),
    .cycle_done(cycle_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // expected {pin_out, cycle_done, busy}, one entry per clk
  logic [2:0] expq[$];

  // reference model: generator position within its cycle plus pin history
  bit m_run, m_tog, m_app;
  int m_pos, m_pm, m_t, m_last, m_sper, m_shi;

  task automatic model_reset();
    m_run = 0; m_tog = 0; m_app = 0;
    m_pos = 0; m_pm = 0; m_t = 0; m_last = 0; m_sper = 0; m_shi = 0;
  endtask

  // Called with this clk's inputs applied; queues the outputs seen after the edge.
  task automatic model_step();
    int  per_e, hi_e;
    bit  lvl, done, stop, was_run;
    per_e = int'(period);
    hi_e  = int'(high_time);
`ifdef SHADOW_CFG_EN
    if (m_run) begin per_e = m_sper; hi_e = m_shi; end
`endif
    // level currently generated
    if (!m_run)        lvl = 0;
    else if (m_pm == 2) lvl = (m_pos < hi_e);
    else if (m_pm == 1) lvl = m_tog;
    else               lvl = 1;
    // pin may only change once the last change is MIN_HOLD clk old
    if (m_t - m_last >= MIN_HOLD && lvl != m_app) begin
      m_app  = lvl;
      m_last = m_t;
    end
    m_t++;
    done    = 0;
    was_run = m_run;
    stop = !enable || mode == 2'b00 || (mode != 2'b11 && per_e == 0) || int'(mode) != m_pm;
    if (stop) begin
      m_run = 0; m_pos = 0;
    end else if (mode == 2'b10 || mode == 2'b01) begin
      if (!m_run) begin
        m_run = 1; m_pos = 0; m_tog = 1;
      end else if (tick) begin
        if (m_pos + 1 >= per_e) begin m_pos = 0; done = 1; m_tog = !m_tog; end
        else m_pos++;
      end
    end else begin
      if (!m_run) begin
        if (start && hi_e != 0) begin m_run = 1; m_pos = 0; end
      end else if (tick) begin
        m_pos++;
        if (m_pos >= hi_e) begin m_run = 0; m_pos = 0; done = 1; end
      end
    end
`ifdef SHADOW_CFG_EN
    if (!was_run || done) begin m_sper = int'(period); m_shi = int'(high_time); end
`else
    if (was_run && done) m_sper = m_sper;
`endif
    m_pm = int'(mode);
    expq.push_back({m_app ^ polarity, done, m_run});
  endtask

  // inputs are set at posedge+1; model then one clk
  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    enable = 0; mode = 2'b00; start = 0;
    repeat (n) step();
  endtask

  task automatic release_rst();
    rst = 0;
    model_reset();
    expq.push_back(3'b000);
  endtask

  // monitor: compare whatever the DUT shows this clk against the queue head
  initial begin
    logic [2:0] e, act;
    forever begin
      @(negedge clk);
      if (!rst && expq.size() > 0) begin
        e   = expq.pop_front();
        act = {pin_out, cycle_done, busy};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL out @%0t pin/cd/busy got=%b want=%b", $time, act, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    release_rst();

    // PWM, period 4, high 1: hold stretches the high level to 2 clk
    enable = 1; mode = 2'b10; period = 8'd4; high_time = 8'd1; tick = 1; polarity = 0;
    repeat (40) step();

    // PWM, tick every 3 clk, period 5, high 2, both polarities
    idle(3);
    period = 8'd5; high_time = 8'd2; enable = 1; mode = 2'b10;
    for (int i = 0; i < 60; i++) begin tick = (i % 3 == 0); step(); end
    idle(3);
    polarity = 1; enable = 1; mode = 2'b10;
    for (int i = 0; i < 60; i++) begin tick = (i % 3 == 0); step(); end
    polarity = 0;

    // one-shot with tick on the start clk, second start ignored
    idle(3);
    high_time = 8'd3; tick = 1; enable = 1; mode = 2'b11;
    step();
    start = 1; step();
    start = 1; step();
    start = 0; repeat (8) step();
    high_time = 8'd0; start = 1; step();
    start = 0; repeat (3) step();

    // toggle period 2, then mode off mid-cycle
    idle(3);
    period = 8'd2; tick = 1; enable = 1; mode = 2'b01;
    repeat (21) step();
    mode = 2'b00; repeat (6) step();

    // PWM boundaries: high >= period, high == 0, period == 0
    idle(3);
    period = 8'd3; high_time = 8'd5; enable = 1; mode = 2'b10; repeat (20) step();
    idle(3);
    high_time = 8'd0; enable = 1; mode = 2'b10; repeat (20) step();
    idle(3);
    period = 8'd0; high_time = 8'd2; enable = 1; mode = 2'b10; repeat (10) step();

    // async reset while the pin is high
    idle(3);
    period = 8'd4; high_time = 8'd2; enable = 1; mode = 2'b10; tick = 1;
    for (int i = 0; i < 20 && !(expq.size() > 0 && expq[0][2]); i++) step();
    rst = 1;
    #1;
    total++;
    if ({pin_out, cycle_done, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async pin/cd/busy got=%b want=000", {pin_out, cycle_done, busy});
    end
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    release_rst();
    repeat (12) step();

    // high_time rewritten 4 -> 2 while cnt == 1
    idle(3);
    period = 8'd8; high_time = 8'd4; enable = 1; mode = 2'b10; tick = 1;
    step();
    for (int i = 0; i < 20 && !(m_run && m_pos == 1); i++) step();
    high_time = 8'd2; step();
    repeat (30) step();

    // random traffic; config only rewritten while the generator is idle
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 19) != 0);
      tick   = ($urandom_range(0, 2) == 0);
      start  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) polarity = ~polarity;
      if (!m_run && $urandom_range(0, 3) == 0) begin
        period    = 8'($urandom_range(0, 6));
        high_time = 8'($urandom_range(0, 7));
      end
      step();
    end

    idle(2);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
